// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register sequencer.
// Op, fill, register mode and FSM state codes.
package usr_pkg;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_SHIFT_R = 2'b01;
    localparam logic [1:0] OP_SHIFT_L = 2'b10;
    localparam logic [1:0] OP_LOAD    = 2'b11;

    localparam logic [1:0] FILL_ZERO   = 2'b00;
    localparam logic [1:0] FILL_ONE    = 2'b01;
    localparam logic [1:0] FILL_ROTATE = 2'b10;
    localparam logic [1:0] FILL_ARITH  = 2'b11;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/usr_shift_counter.sv
// Shift-count down-counter: loads at command acceptance, steps once per
// shift cycle, and flags the final cycle so the FSM never sees a wrap.
module usr_shift_counter
    import usr_pkg::*;
#(
    parameter int CNT_WIDTH = 3
) (
    input  logic                 i_clk,
    input  logic                 i_clr,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_value,
    input  logic                 i_dec,
    output logic                 o_last,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
        end
    end

    assign o_last  = (r_cnt == CNT_WIDTH'(1));
    assign o_count = r_cnt;

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command sequencer driving a 4-bit universal shift register:
// one command per handshake, registered mode/data, live serial fill.
module usr_shift_sequencer
    import usr_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int DATA_WIDTH1 = 2,
    parameter int CNT_WIDTH   = 3
) (
    input  logic                   i_clk,
    input  logic                   clr,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [1:0]             cmd_fill,
    input  logic [CNT_WIDTH-1:0]   cmd_count,
    input  logic [DATA_WIDTH-1:0]  cmd_data,
    input  logic [DATA_WIDTH-1:0]  q_in,
    output logic [DATA_WIDTH1-1:0] sel_mux,
    output logic [DATA_WIDTH-1:0]  par_out,
    output logic                   sr,
    output logic                   sl,
    output logic                   busy,
    output logic                   done
);

    state_t                  r_state;
    state_t                  w_next;
    logic [1:0]              r_op;
    logic [1:0]              r_fill;
    logic [DATA_WIDTH-1:0]   r_par;
    logic [DATA_WIDTH1-1:0]  r_sel;
    logic [DATA_WIDTH1-1:0]  w_sel_next;
    logic                    r_done;
    logic                    r_busy;
    logic                    r_ready;
    logic                    w_accept;
    logic                    w_is_shift;
    logic                    w_last;
    logic [1:0]              w_op;
    logic                    w_sr;
    logic                    w_sl;
    logic [CNT_WIDTH-1:0]    w_count;

    assign w_accept   = cmd_valid && r_ready;
    assign w_is_shift = (cmd_op == OP_SHIFT_R) || (cmd_op == OP_SHIFT_L);
    assign w_op       = w_accept ? cmd_op : r_op;

    usr_shift_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .i_clk   (i_clk),
        .i_clr   (clr),
        .i_load  (w_accept),
        .i_value (cmd_count),
        .i_dec   (r_state == S_SHIFT),
        .o_last  (w_last),
        .o_count (w_count)
    );

    always_comb begin
        w_next     = r_state;
        w_sel_next = SEL_HOLD;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_op == OP_LOAD) begin
                        w_next = S_LOAD;
                    end else if (w_is_shift && (cmd_count != '0)) begin
                        w_next = S_SHIFT;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_LOAD:  w_next = S_DONE;
            S_SHIFT: if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Outputs are registered, so decode them from the next state.
        case (w_next)
            S_LOAD:  w_sel_next = SEL_LOAD;
            S_SHIFT: w_sel_next = (w_op == OP_SHIFT_L) ? SEL_SHL : SEL_SHR;
            default: w_sel_next = SEL_HOLD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_op    <= OP_NOP;
            r_fill  <= FILL_ZERO;
            r_par   <= '0;
            r_sel   <= SEL_HOLD;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= cmd_op;
                r_fill <= cmd_fill;
            end
            if (w_accept && (cmd_op == OP_LOAD)) begin
                r_par <= cmd_data;
            end
            r_sel   <= w_sel_next;
            r_done  <= (w_next == S_DONE);
            r_busy  <= (w_next != S_IDLE);
            r_ready <= (w_next == S_IDLE);
        end
    end

    always_comb begin
        w_sr = 1'b0;
        w_sl = 1'b0;
        if (r_state == S_SHIFT) begin
            case (r_fill)
                FILL_ONE: begin
                    w_sr = 1'b1;
                    w_sl = 1'b1;
                end
                FILL_ROTATE: begin
                    w_sr = q_in[0];
                    w_sl = q_in[DATA_WIDTH-1];
                end
                FILL_ARITH: w_sr = q_in[DATA_WIDTH-1];
                default: begin
                    w_sr = 1'b0;
                    w_sl = 1'b0;
                end
            endcase
        end
    end

    logic w_unused;
    assign w_unused = ^w_count;

    assign cmd_ready = r_ready;
    assign sel_mux   = r_sel;
    assign par_out   = r_par;
    assign sr        = w_sr;
    assign sl        = w_sl;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
